// File: rtl/program_loader.sv
// program_loader: framed byte stream to instruction/data BRAM word writes, releases core on end marker
module program_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic                  pc_stall,
  output logic                  d_bram_init_done,
  output logic                  i_r_enb,
  output logic                  load_done,
  output logic                  load_error
);
  typedef enum logic [2:0] {S_TGT, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);
  state_t r_state, w_next;
  logic r_tgt;
  logic [7:0] r_cnt_lo;
  logic [15:0] r_cnt, r_word_idx;
  logic [1:0] r_byte_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic w_xfer, w_wr;
  logic [15:0] w_cnt;
  logic [DATA_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_addr;
  assign w_xfer = in_valid & in_ready;
  assign w_cnt  = {in_data, r_cnt_lo};
  assign w_word = {in_data, r_word[DATA_WIDTH-1:8]};
  assign w_addr = {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
  assign w_wr   = w_next == S_WRITE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TGT:    if (w_xfer) w_next = (in_data == 8'h00 || in_data == 8'h01) ? S_CNT_LO :
                                     (in_data == 8'hFF) ? S_DONE : S_ERR;
      S_CNT_LO: if (w_xfer) w_next = S_CNT_HI;
      S_CNT_HI: if (w_xfer) w_next = (w_cnt == 16'd0) ? S_TGT : (w_cnt > MAX_CNT) ? S_ERR : S_DATA;
      S_DATA:   if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
      S_WRITE:  w_next = (r_word_idx + 16'd1 == r_cnt) ? S_TGT : S_DATA;
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_TGT;
      r_tgt            <= 1'b0;
      r_cnt_lo         <= '0;
      r_cnt            <= '0;
      r_word_idx       <= '0;
      r_byte_idx       <= '0;
      r_word           <= '0;
      in_ready         <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      i_w_byte_enb     <= 4'b0000;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      d_w_byte_enb     <= 4'b0000;
      pc_stall         <= 1'b1;
      d_bram_init_done <= 1'b0;
      i_r_enb          <= 1'b0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
    end else begin
      r_state          <= w_next;
      in_ready         <= w_next inside {S_TGT, S_CNT_LO, S_CNT_HI, S_DATA};
      i_w_enb          <= w_wr & ~r_tgt;
      d_w_enb          <= w_wr & r_tgt;
      i_w_byte_enb     <= {4{w_wr & ~r_tgt}};
      d_w_byte_enb     <= {4{w_wr & r_tgt}};
      pc_stall         <= w_next != S_DONE;
      d_bram_init_done <= w_next == S_DONE;
      i_r_enb          <= w_next == S_DONE;
      load_done        <= w_next == S_DONE;
      load_error       <= w_next == S_ERR;
      if (r_state == S_TGT && w_xfer) r_tgt <= in_data[0];
      if (r_state == S_CNT_LO && w_xfer) r_cnt_lo <= in_data;
      if (r_state == S_CNT_HI && w_xfer) begin
        r_cnt      <= w_cnt;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end
      if (r_state == S_DATA && w_xfer) begin
        r_word     <= w_word;
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state == S_WRITE) r_word_idx <= r_word_idx + 16'd1;
      if (w_wr && !r_tgt) begin
        i_w_addr <= w_addr;
        i_w_dat  <= w_word;
      end
      if (w_wr && r_tgt) begin
        d_w_addr <= w_addr;
        d_w_dat  <= w_word;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, i_w_enb, d_w_enb, pc_stall, d_bram_init_done, i_r_enb, load_done, load_error;
  logic [11:0] i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic [3:0] i_w_byte_enb, d_w_byte_enb;
  int tests = 0, fails = 0;
  logic [31:0] ia[$], id[$], da[$], dd[$];
  logic [3:0] ib[$], db[$];
  program_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
    .pc_stall(pc_stall), .d_bram_init_done(d_bram_init_done), .i_r_enb(i_r_enb),
    .load_done(load_done), .load_error(load_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (i_w_enb) begin
      ia.push_back(32'(i_w_addr));
      id.push_back(i_w_dat);
      ib.push_back(i_w_byte_enb);
    end
    if (d_w_enb) begin
      da.push_back(32'(d_w_addr));
      dd.push_back(d_w_dat);
      db.push_back(d_w_byte_enb);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_q();
    ia.delete(); id.delete(); ib.delete();
    da.delete(); dd.delete(); db.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input int gap = 0);
    int n = 0;
    if (gap > 0) idle(gap);
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit bubbles = 0);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8], bubbles ? int'($urandom_range(0, 2)) : 0);
  endtask
  task automatic chk_done(input string tag);
    chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    chk({tag, "_pc_stall"}, 64'(pc_stall), 64'd0);
    chk({tag, "_i_r_enb"}, 64'(i_r_enb), 64'd1);
    chk({tag, "_dinit"}, 64'(d_bram_init_done), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_err"}, 64'(load_error), 64'd0);
  endtask
  task automatic instr_two(input bit bubbles, input string tag);
    send(8'h00); send(8'h02); send(8'h00);
    send_word(32'h00500513, bubbles);
    send_word(32'h00600593, bubbles);
    idle(3);
    chk({tag, "_icount"}, 64'(ia.size()), 64'd2);
    chk({tag, "_dcount"}, 64'(da.size()), 64'd0);
    chk({tag, "_a0"}, 64'(ia[0]), 64'h000);
    chk({tag, "_d0"}, 64'(id[0]), 64'h00500513);
    chk({tag, "_be0"}, 64'(ib[0]), 64'hF);
    chk({tag, "_a1"}, 64'(ia[1]), 64'h004);
    chk({tag, "_d1"}, 64'(id[1]), 64'h00600593);
    chk({tag, "_be1"}, 64'(ib[1]), 64'hF);
    chk({tag, "_hold_addr"}, 64'(i_w_addr), 64'h004);
    chk({tag, "_hold_dat"}, 64'(i_w_dat), 64'h00600593);
    chk({tag, "_idle_enb"}, 64'({i_w_enb, i_w_byte_enb}), 64'h0);
    chk({tag, "_pre_done"}, 64'({load_done, pc_stall}), 64'h1);
    send(8'hFF);
    chk_done(tag);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pc_stall", 64'(pc_stall), 64'd1);
    chk("rst_enables", 64'({i_w_enb, d_w_enb, i_w_byte_enb, d_w_byte_enb}), 64'h0);
    chk("rst_addr_dat", 64'({i_w_addr, d_w_addr, i_w_dat}), 64'h0);
    chk("rst_flags", 64'({i_r_enb, d_bram_init_done, load_done, load_error}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    clear_q();
    instr_two(0, "instr");
    do_reset();
    clear_q();
    send(8'h01); send(8'h03); send(8'h00);
    send_word(32'd5); send_word(32'd6); send_word(32'd1);
    send(8'h00); send(8'h01); send(8'h00);
    send_word(32'h12345678);
    idle(2);
    chk("mix_dcount", 64'(da.size()), 64'd3);
    chk("mix_dwr0", {da[0], dd[0]}, {32'h0, 32'd5});
    chk("mix_dwr1", {da[1], dd[1]}, {32'h4, 32'd6});
    chk("mix_dwr2", {da[2], dd[2]}, {32'h8, 32'd1});
    chk("mix_dbe", 64'({db[0], db[1], db[2]}), 64'hFFF);
    chk("mix_icount", 64'(ia.size()), 64'd1);
    chk("mix_iwr0", {ia[0], id[0]}, {32'h0, 32'h12345678});
    chk("mix_dinit_early", 64'(d_bram_init_done), 64'd0);
    send(8'hFF);
    chk_done("mix");
    do_reset();
    clear_q();
    instr_two(1, "bubble");
    do_reset();
    clear_q();
    send(8'h00); send(8'h00); send(8'h00); send(8'hFF);
    idle(2);
    chk("zero_writes", 64'(ia.size() + da.size()), 64'd0);
    chk_done("zero");
    do_reset();
    clear_q();
    send(8'h07);
    idle(3);
    chk("badtgt_err", 64'(load_error), 64'd1);
    chk("badtgt_stall", 64'(pc_stall), 64'd1);
    chk("badtgt_ready", 64'(in_ready), 64'd0);
    chk("badtgt_done", 64'({load_done, d_bram_init_done}), 64'd0);
    do_reset();
    chk("err_cleared", 64'({load_error, in_ready}), 64'h1);
    send(8'h00); send(8'h00); send(8'h04);
    idle(2);
    chk("cnt1024_ok", 64'({load_error, in_ready}), 64'h1);
    do_reset();
    clear_q();
    send(8'h00); send(8'h01); send(8'h04);
    idle(3);
    chk("cnt1025_err", 64'(load_error), 64'd1);
    chk("cnt1025_ready", 64'(in_ready), 64'd0);
    chk("cnt1025_writes", 64'(ia.size() + da.size()), 64'd0);
    do_reset();
    clear_q();
    send(8'h00); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    do_reset();
    chk("midrst_nowrite", 64'(ia.size() + da.size()), 64'd0);
    send(8'h00); send(8'h01); send(8'h00);
    send_word(32'hDEADBEEF);
    idle(2);
    chk("reload_count", 64'(ia.size()), 64'd1);
    chk("reload_wr", {ia[0], id[0]}, {32'h0, 32'hDEADBEEF});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
